motoro3_ramp_ctrl: RTL and testbench

//  Speed-ramp sequencer for the 3-phase step generator. Owns the generator's m3start enable and 25-bit step period.

---
 rtl/motoro3_ramp_ctrl_pkg.sv | 31 +++
 rtl/motoro3_stall_wdog.sv | 45 ++++
 rtl/motoro3_ramp_ctrl.sv | 134 +++++++++++++
 tb/tb_motoro3_ramp_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_ramp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : motoro3_ramp_ctrl_pkg                                          |
// | Desc    : State codes and default constants for the motor ramp control.  |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package motoro3_ramp_ctrl_pkg;

  localparam int M3_PERIOD_W     = 25;
  localparam int M3_START_PERIOD = 1_666_667;
  localparam int M3_MIN_PERIOD   = 1_667;
  localparam int M3_RAMP_STEP    = 16_667;
  localparam int M3_WDOG_CYCLES  = 4_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STOP  = 3'd3,
    ST_FAULT = 3'd4
  } m3_state_e;

  // The generator is enabled in every state that owns a live period.
  function automatic logic m3_is_running(input m3_state_e s);
    return (s == ST_RAMP) || (s == ST_RUN) || (s == ST_STOP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/motoro3_stall_wdog.sv
// ---------------------------------------------------------------------------
// | Module  : motoro3_stall_wdog                                             |
// | Desc    : Stall watchdog; flags when no step tick arrives in WDOG_CYCLES. |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module motoro3_stall_wdog #(
  parameter int WDOG_CYCLES = 4_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

`default_nettype wire

// File: rtl/motoro3_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : motoro3_ramp_ctrl                                              |
// | Desc    : Speed-ramp sequencer driving the 3-phase step generator.       |
// |           Optional stall watchdog enabled by M3_STALL_WDOG_EN.           |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module motoro3_ramp_ctrl
  import motoro3_ramp_ctrl_pkg::*;
#(
  parameter int PERIOD_W     = M3_PERIOD_W,
  parameter int START_PERIOD = M3_START_PERIOD,
  parameter int MIN_PERIOD   = M3_MIN_PERIOD,
  parameter int RAMP_STEP    = M3_RAMP_STEP,
  parameter int WDOG_CYCLES  = M3_WDOG_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                fault_clr,
  input  logic [PERIOD_W-1:0] target_period,
  input  logic                step_tick,
  output logic                m3start,
  output logic [PERIOD_W-1:0] m3period,
  output logic [2:0]          state,
  output logic                busy,
  output logic                at_speed,
  output logic                fault
);

  localparam int W1 = PERIOD_W + 1;
  localparam logic [W1-1:0] START_X = W1'(START_PERIOD);
  localparam logic [W1-1:0] MIN_X   = W1'(MIN_PERIOD);
  localparam logic [W1-1:0] STEP_X  = W1'(RAMP_STEP);

  m3_state_e           state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                wdog_expired;

  logic [W1-1:0] per_x, tp_x, tgt_x, diff_x, delta_x, ramp_next_x, stop_sum_x, stop_next_x;

  // One-bit headroom keeps the add/subtract from wrapping before saturation.
  always_comb begin
    per_x       = {1'b0, period_q};
    tp_x        = {1'b0, target_period};
    tgt_x       = (tp_x < MIN_X) ? MIN_X : ((tp_x > START_X) ? START_X : tp_x);
    diff_x      = (per_x > tgt_x) ? (per_x - tgt_x) : (tgt_x - per_x);
    delta_x     = (diff_x < STEP_X) ? diff_x : STEP_X;
    ramp_next_x = (per_x > tgt_x) ? (per_x - delta_x) : (per_x + delta_x);
    stop_sum_x  = per_x + STEP_X;
    stop_next_x = (stop_sum_x > START_X) ? START_X : stop_sum_x;
  end

`ifdef M3_STALL_WDOG_EN
  motoro3_stall_wdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_stall_wdog (
    .clk       (clk),
    .rst       (rst),
    .en_i      (m3start),
    .clear_i   (step_tick | ~m3start),
    .expired_o (wdog_expired)
  );
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    case (state_q)
      ST_IDLE: begin
        period_d = START_X[PERIOD_W-1:0];
        if (cmd_start && !cmd_stop) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (cmd_stop) begin
          state_d = ST_STOP;
        end else if (step_tick) begin
          period_d = ramp_next_x[PERIOD_W-1:0];
          if (ramp_next_x == tgt_x) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cmd_stop)              state_d = ST_STOP;
        else if (tgt_x != per_x)   state_d = ST_RAMP;
      end
      ST_STOP: begin
        if (cmd_start && !cmd_stop) begin
          state_d = ST_RAMP;
        end else if (step_tick) begin
          if (per_x == START_X) state_d  = ST_IDLE;
          else                  period_d = stop_next_x[PERIOD_W-1:0];
        end
      end
      ST_FAULT: begin
        period_d = START_X[PERIOD_W-1:0];
        if (fault_clr) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        period_d = START_X[PERIOD_W-1:0];
      end
    endcase
    // A stall overrides any ramp activity and parks the generator.
    if (wdog_expired && m3start) begin
      state_d  = ST_FAULT;
      period_d = START_X[PERIOD_W-1:0];
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= START_X[PERIOD_W-1:0];
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
    end
  end

  assign m3start  = m3_is_running(state_q);
  assign m3period = period_q;
  assign state    = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign at_speed = (state_q == ST_RUN);
  assign fault    = (state_q == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_motoro3_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : tb_motoro3_ramp_ctrl                                           |
// | Desc    : Self-checking bench for motoro3_ramp_ctrl (small parameters).  |
// | Rev     : 1.0  initial release                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_motoro3_ramp_ctrl;

  localparam int PW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start, cmd_stop, fault_clr, step_tick;
  logic [PW-1:0] target_period;
  logic          m3start, busy, at_speed, fault;
  logic [PW-1:0] m3period;
  logic [2:0]    state;

  motoro3_ramp_ctrl #(
    .PERIOD_W     (PW),
    .START_PERIOD (100),
    .MIN_PERIOD   (10),
    .RAMP_STEP    (30),
    .WDOG_CYCLES  (500)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_start     (cmd_start),
    .cmd_stop      (cmd_stop),
    .fault_clr     (fault_clr),
    .target_period (target_period),
    .step_tick     (step_tick),
    .m3start       (m3start),
    .m3period      (m3period),
    .state         (state),
    .busy          (busy),
    .at_speed      (at_speed),
    .fault         (fault)
  );

  // DUT flops on the falling edge; the bench drives and samples on the rising edge.
  always #5 clk = ~clk;

  typedef struct {
    logic s; logic p; logic c; int tgt; logic t;
    logic [2:0] es; int ep;
  } vec_t;

  typedef struct {
    string nm; logic [2:0] st; int per;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic drive(input logic s, input logic p, input logic c, input int tgt, input logic t);
    cmd_start     = s;
    cmd_stop      = p;
    fault_clr     = c;
    target_period = PW'(tgt);
    step_tick     = t;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] st, input int per);
    exp_t e;
    e.nm = nm; e.st = st; e.per = per;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic e_run, e_busy, e_at, e_flt;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e      = sb.pop_front();
    e_run  = (e.st == 3'd1) || (e.st == 3'd2) || (e.st == 3'd3);
    e_busy = (e.st != 3'd0);
    e_at   = (e.st == 3'd2);
    e_flt  = (e.st == 3'd4);
    if (state !== e.st || m3period !== PW'(e.per) || m3start !== e_run ||
        busy !== e_busy || at_speed !== e_at || fault !== e_flt) begin
      bad++;
      $display("FAIL %s: got state=%0d period=%0d m3start=%0b busy=%0b at_speed=%0b fault=%0b, want state=%0d period=%0d m3start=%0b busy=%0b at_speed=%0b fault=%0b",
               e.nm, state, m3period, m3start, busy, at_speed, fault,
               e.st, e.per, e_run, e_busy, e_at, e_flt);
    end
  endtask

  task automatic add(input logic s, input logic p, input logic c, input int tgt, input logic t,
                     input logic [2:0] es, input int ep);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.tgt = tgt; v.t = t; v.es = es; v.ep = ep;
    vq.push_back(v);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(0, 0, 0, 40, 0);

    //   start stop clr tgt tick   state period
    add(0, 0, 0,  40, 0,  3'd0, 100);
    add(1, 0, 0,  40, 0,  3'd1, 100);   // accelerate toward 40
    add(1, 0, 0,  40, 1,  3'd1,  70);
    add(1, 0, 0,  40, 0,  3'd1,  70);
    add(1, 0, 0,  40, 1,  3'd2,  40);
    add(1, 0, 0,  40, 1,  3'd2,  40);
    add(0, 1, 0,  40, 0,  3'd3,  40);   // controlled stop from RUN
    add(0, 1, 0,  40, 1,  3'd3,  70);
    add(0, 1, 0,  40, 1,  3'd3, 100);
    add(0, 1, 0,  40, 1,  3'd0, 100);
    add(0, 0, 0,  40, 1,  3'd0, 100);   // tick ignored in IDLE
    add(1, 1, 0,  40, 0,  3'd0, 100);   // start+stop: stay idle
    add(1, 0, 0,   5, 0,  3'd1, 100);   // target clamps to MIN
    add(1, 0, 0,   5, 1,  3'd1,  70);
    add(1, 0, 0,   5, 1,  3'd1,  40);
    add(1, 0, 0,   5, 1,  3'd2,  10);
    add(1, 0, 0,  50, 0,  3'd1,  10);   // retarget slower
    add(1, 0, 0,  50, 1,  3'd1,  40);
    add(1, 0, 0,  50, 1,  3'd2,  50);
    add(1, 0, 0, 200, 0,  3'd1,  50);   // target clamps to START
    add(1, 0, 0, 200, 1,  3'd1,  80);
    add(1, 0, 0, 200, 1,  3'd2, 100);
    add(1, 0, 0,  40, 0,  3'd1, 100);   // retarget faster
    add(1, 0, 0,  40, 1,  3'd1,  70);
    add(1, 1, 0,  40, 0,  3'd3,  70);   // stop mid-ramp holds period
    add(1, 1, 0,  40, 0,  3'd3,  70);
    add(1, 0, 0,  40, 0,  3'd1,  70);   // resume from current period
    add(1, 0, 0,  40, 1,  3'd2,  40);
    add(0, 1, 0,  40, 0,  3'd3,  40);
    add(0, 1, 0,  40, 1,  3'd3,  70);
    add(0, 1, 0,  40, 1,  3'd3, 100);
    add(0, 1, 0,  40, 1,  3'd0, 100);
    add(0, 0, 1,  40, 0,  3'd0, 100);

    repeat (2) @(posedge clk);
    expect_out("reset_values", 3'd0, 100);
    check_out();
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].s, vq[i].p, vq[i].c, vq[i].tgt, vq[i].t);
      expect_out($sformatf("vec%0d", i), vq[i].es, vq[i].ep);
      @(posedge clk);
      check_out();
    end

    // Asynchronous reset in the middle of a ramp, well away from the active edge.
    drive(1, 0, 0, 40, 0);
    expect_out("rst_seq_ramp", 3'd1, 100);
    @(posedge clk); check_out();
    drive(1, 0, 0, 40, 1);
    expect_out("rst_seq_tick", 3'd1, 70);
    @(posedge clk); check_out();
    drive(0, 0, 0, 40, 0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 3'd0, 100);
    check_out();
    #1 rst = 1'b0;
    expect_out("after_rst", 3'd0, 100);
    @(posedge clk); check_out();

    // Run at START_PERIOD and starve the step ticks.
    drive(1, 0, 0, 100, 0);
    expect_out("stall_ramp", 3'd1, 100);
    @(posedge clk); check_out();
    drive(1, 0, 0, 100, 1);
    expect_out("stall_run", 3'd2, 100);
    @(posedge clk); check_out();
    drive(1, 0, 0, 100, 0);
`ifdef M3_STALL_WDOG_EN
    n = 0;
    while (fault !== 1'b1 && n < 700) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n < 495 || n > 510) begin
      bad++;
      $display("FAIL wdog_latency: got %0d cycles, want 495..510", n);
    end
    expect_out("wdog_fault", 3'd4, 100);
    check_out();
    repeat (3) @(posedge clk);
    expect_out("fault_ignores_start", 3'd4, 100);
    check_out();
    drive(0, 0, 1, 100, 0);
    expect_out("fault_clr", 3'd0, 100);
    @(posedge clk); check_out();
    drive(0, 0, 0, 100, 0);
`else
    n = 0;
    repeat (600) begin
      @(posedge clk);
      n++;
    end
    expect_out("no_wdog_run", 3'd2, 100);
    check_out();
    drive(1, 0, 1, 100, 0);
    expect_out("no_wdog_clr_ignored", 3'd2, 100);
    @(posedge clk); check_out();
    drive(0, 0, 0, 100, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
